// File: rtl/flex_cnt_pkg.sv
// Shared definitions for the flex up/down counter.
//   DIR_UP / DIR_DOWN : encoding of the count_down input.
//   cnt_t             : wide unsigned working type; channel widths up to
//                       CNT_W_MAX are zero-extended into it, so no compare
//                       or +/-1 ever truncates.
//   flex_next_count   : next count for one enabled channel.
//   flex_is_wrap      : the advance starts from the terminal value.
//   flex_is_term      : a given next count is the terminal value.
package flex_cnt_pkg;

    localparam int   CNT_W_MAX = 32;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    typedef logic [CNT_W_MAX-1:0] cnt_t;

    // Up:   count < R -> count+1, otherwise 1.
    // Down: 1 < count <= R -> count-1, otherwise R.
    // R == 0 pins the channel at zero.
    function automatic cnt_t flex_next_count(input cnt_t count, input cnt_t r,
                                             input logic down);
        cnt_t nxt;
        if (r == '0)
            nxt = '0;
        else if (down == DIR_UP)
            nxt = (count < r) ? count + cnt_t'(1) : cnt_t'(1);
        else
            nxt = (count > cnt_t'(1) && count <= r) ? count - cnt_t'(1) : r;
        return nxt;
    endfunction

    // Only a true terminal-value advance is a wrap; out-of-range
    // corrections (e.g. 0 -> R in down mode) are not.
    function automatic logic flex_is_wrap(input cnt_t count, input cnt_t r,
                                          input logic down);
        if (r == '0)
            return 1'b0;
        return (down == DIR_UP) ? (count == r) : (count == cnt_t'(1));
    endfunction

    function automatic logic flex_is_term(input cnt_t nxt, input cnt_t r,
                                          input logic down);
        if (r == '0)
            return 1'b0;
        return (down == DIR_UP) ? (nxt == r) : (nxt == cnt_t'(1));
    endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// One channel of the flex up/down counter.
// Optional feature: FLEX_CNT_LOAD_EN adds load / load_val.
// Ports:
//   clk, n_rst        clock, async active-low reset
//   clear             synchronous clear (highest priority)
//   load, load_val    parallel load (FLEX_CNT_LOAD_EN only)
//   count_enable      advance request
//   count_down        direction (DIR_DOWN = 1)
//   rollover_val      terminal value R
//   count_out         registered count
//   rollover_flag     registered: count_out is the terminal value
//   wrap_pulse        registered one-cycle pulse after a wrap
// NUM_CNT_BITS must not exceed flex_cnt_pkg::CNT_W_MAX.
module flex_counter_ch
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
`ifdef FLEX_CNT_LOAD_EN
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
`endif
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse
);

    cnt_t cur_w;
    cnt_t r_w;
    cnt_t nxt_w;
    logic nxt_wrap;
    logic nxt_flag;

    always_comb begin
        cur_w    = cnt_t'(count_out);
        r_w      = cnt_t'(rollover_val);
        nxt_w    = cur_w;
        nxt_wrap = 1'b0;
        if (clear)
            nxt_w = '0;
`ifdef FLEX_CNT_LOAD_EN
        // R == 0 pins the channel at zero even against a load.
        else if (load)
            nxt_w = (r_w == '0) ? '0 : cnt_t'(load_val);
`endif
        else if (r_w == '0)
            nxt_w = '0;
        else if (count_enable) begin
            nxt_w    = flex_next_count(cur_w, r_w, count_down);
            nxt_wrap = flex_is_wrap(cur_w, r_w, count_down);
        end
        // Flag comes from the next state, so it lines up with count_out and
        // follows R / direction changes even while the channel holds.
        nxt_flag = flex_is_term(nxt_w, r_w, count_down);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else begin
            count_out     <= NUM_CNT_BITS'(nxt_w);
            rollover_flag <= nxt_flag;
            wrap_pulse    <= nxt_wrap;
        end
    end

endmodule

// File: rtl/flex_updown_counter.sv
// NUM_CH independent flex up/down counters with packed per-channel buses.
// Optional feature: FLEX_CNT_LOAD_EN adds load / load_val.
// Ports (channel i uses bit i, or bits [i*NUM_CNT_BITS +: NUM_CNT_BITS]):
//   clk, n_rst        clock, async active-low reset
//   clear             per-channel synchronous clear
//   load, load_val    per-channel parallel load (FLEX_CNT_LOAD_EN only)
//   count_enable      per-channel advance request
//   count_down        per-channel direction, 1 = down
//   rollover_val      packed terminal values
//   count_out         packed registered counts
//   rollover_flag     per-channel terminal-count flag
//   wrap_pulse        per-channel one-cycle wrap pulse
module flex_updown_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_CH-1:0]              clear,
`ifdef FLEX_CNT_LOAD_EN
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
`endif
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              count_down,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              wrap_pulse
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(
            .NUM_CNT_BITS (NUM_CNT_BITS)
        ) u_ch (
            .clk           (clk),
            .n_rst         (n_rst),
            .clear         (clear[i]),
`ifdef FLEX_CNT_LOAD_EN
            .load          (load[i]),
            .load_val      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
`endif
            .count_enable  (count_enable[i]),
            .count_down    (count_down[i]),
            .rollover_val  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_out     (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag (rollover_flag[i]),
            .wrap_pulse    (wrap_pulse[i])
        );
    end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed bench for flex_updown_counter (NUM_CNT_BITS=4, NUM_CH=2).
// Load scenario is compiled only with FLEX_CNT_LOAD_EN.
module tb_flex_updown_counter;

    logic       clk;
    logic       n_rst;
    logic [1:0] clear;
    logic [1:0] count_enable;
    logic [1:0] count_down;
    logic [7:0] rollover_val;
    logic [7:0] count_out;
    logic [1:0] rollover_flag;
    logic [1:0] wrap_pulse;
`ifdef FLEX_CNT_LOAD_EN
    logic [1:0] load;
    logic [7:0] load_val;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // ch0 R=3 up, ch1 R=4 down, both enabled from reset
    logic [3:0] c0_tab [7] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1};
    logic [3:0] c1_tab [7] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd4, 4'd3, 4'd2};
    logic [1:0] fl_tab [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0] wr_tab [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};

    flex_updown_counter #(
        .NUM_CNT_BITS (4),
        .NUM_CH       (2)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
`ifdef FLEX_CNT_LOAD_EN
        .load          (load),
        .load_val      (load_val),
`endif
        .count_enable  (count_enable),
        .count_down    (count_down),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .wrap_pulse    (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst        = 1'b0;
        clear        = 2'b00;
        count_enable = 2'b00;
        count_down   = 2'b00;
        rollover_val = 8'h00;
`ifdef FLEX_CNT_LOAD_EN
        load         = 2'b00;
        load_val     = 8'h00;
`endif
        #2;
        chk("rst_cnt",  32'(count_out),     32'h0);
        chk("rst_flag", 32'(rollover_flag), 32'h0);
        chk("rst_wrap", 32'(wrap_pulse),    32'h0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // up wrap on ch0 and down wrap on ch1 side by side
        rollover_val = {4'd4, 4'd3};
        count_down   = 2'b10;
        count_enable = 2'b11;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("wrap_cnt",  32'(count_out),     32'({c1_tab[i], c0_tab[i]}));
            chk("wrap_flag", 32'(rollover_flag), 32'(fl_tab[i]));
            chk("wrap_wp",   32'(wrap_pulse),    32'(wr_tab[i]));
        end

        // ch0 -> 2, ch1 -> 1
        step();
        chk("pre_clr_cnt",  32'(count_out),     32'h12);
        chk("pre_clr_flag", 32'(rollover_flag), 32'h2);

        // clear beats enable on ch0; ch1 keeps counting (1 -> 4, wrap)
        clear = 2'b01;
        step();
        chk("clr_cnt",  32'(count_out),     32'h40);
        chk("clr_flag", 32'(rollover_flag), 32'h0);
        chk("clr_wrap", 32'(wrap_pulse),    32'h2);

        // enable off, ch1 flips to up: flag re-evaluated (count 4 == R)
        clear        = 2'b00;
        count_enable = 2'b00;
        count_down   = 2'b00;
        step();
        chk("dir_cnt",  32'(count_out),     32'h40);
        chk("dir_flag", 32'(rollover_flag), 32'h2);
        chk("dir_wrap", 32'(wrap_pulse),    32'h0);

        // R=0 on ch0: pinned at zero despite enable
        rollover_val = {4'd4, 4'd0};
        count_enable = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r0_cnt",  32'(count_out),     32'h40);
            chk("r0_flag", 32'(rollover_flag), 32'h2);
            chk("r0_wrap", 32'(wrap_pulse),    32'h0);
        end

        // R=1 on ch0: 0 -> 1 without wrap, then 1 -> 1 wrapping each cycle
        rollover_val = {4'd4, 4'd1};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r1_cnt",  32'(count_out[3:0]),   32'h1);
            chk("r1_flag", 32'(rollover_flag[0]), 32'h1);
            chk("r1_wrap", 32'(wrap_pulse[0]),    (i == 0) ? 32'h0 : 32'h1);
        end

        // R=9 on ch0, count to 5, then pulse reset between edges
        clear = 2'b01;
        step();
        clear        = 2'b00;
        rollover_val = {4'd4, 4'd9};
        repeat (5) step();
        chk("pre_rst_cnt", 32'(count_out[3:0]), 32'h5);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_cnt",  32'(count_out),     32'h0);
        chk("mid_rst_flag", 32'(rollover_flag), 32'h0);
        chk("mid_rst_wrap", 32'(wrap_pulse),    32'h0);
        #2;
        n_rst = 1'b1;
        repeat (2) step();
        chk("post_rst_cnt",  32'(count_out),     32'h02);
        chk("post_rst_flag", 32'(rollover_flag), 32'h0);

`ifdef FLEX_CNT_LOAD_EN
        // load R on ch0: terminal flag, no wrap; next advance wraps to 1
        rollover_val = {4'd4, 4'd7};
        load         = 2'b01;
        load_val     = {4'd0, 4'd7};
        step();
        chk("ld_cnt",  32'(count_out[3:0]),   32'h7);
        chk("ld_flag", 32'(rollover_flag[0]), 32'h1);
        chk("ld_wrap", 32'(wrap_pulse[0]),    32'h0);
        load = 2'b00;
        step();
        chk("ld_adv_cnt",  32'(count_out[3:0]),   32'h1);
        chk("ld_adv_flag", 32'(rollover_flag[0]), 32'h0);
        chk("ld_adv_wrap", 32'(wrap_pulse[0]),    32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/flex_updown_counter.md
FLEX_UPDOWN_COUNTER -- requirements
Module: flex_updown_counter

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, meaning the counter width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2, meaning the number of independent counter channels.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clear, input, NUM_CH bits: per-channel synchronous clear.
REQ-006 SHALL have port count_enable, input, NUM_CH bits: per-channel advance request.
REQ-007 SHALL have port count_down, input, NUM_CH bits: per-channel direction; 1 means down, 0 means up.
REQ-008 SHALL have port rollover_val, input, NUM_CH*NUM_CNT_BITS bits: packed terminal value R; channel i occupies bits [i*NUM_CNT_BITS +: NUM_CNT_BITS].
REQ-009 SHALL have port count_out, output, NUM_CH*NUM_CNT_BITS bits: packed registered count, packed the same way as rollover_val.
REQ-010 SHALL have port rollover_flag, output, NUM_CH bits: registered terminal-count flag.
REQ-011 SHALL have port wrap_pulse, output, NUM_CH bits: one-cycle registered pulse on each wrap.

Function
REQ-012 Each channel SHALL operate independently; there SHALL be no cross-channel interaction.
REQ-013 Priority per channel SHALL be clear > load (when compiled in) > count_enable > hold.
REQ-014 On clear, the channel SHALL set count to 0, rollover_flag to 0 and wrap_pulse to 0 on the next edge.
REQ-015 In up mode with enable high, the next count SHALL be count+1 if count < R, and 1 if count >= R (wrap).
REQ-016 In down mode with enable high, the next count SHALL be count-1 if 1 < count <= R, and R if count <= 1 or count > R (wrap).
REQ-017 A wrap SHALL be any enabled advance from the terminal value: count==R in up mode, count==1 in down mode. Only that case SHALL assert wrap_pulse for exactly the following cycle. Out-of-range corrections (count > R in up mode; count==0 or count > R in down mode) SHALL NOT assert wrap_pulse.
REQ-018 rollover_flag SHALL be registered from the next-state count and direction: high when the next count equals R in up mode, or equals 1 in down mode. It SHALL therefore be aligned with count_out and carry no extra cycle of latency.
REQ-019 When enable is low, count and rollover_flag SHALL be re-evaluated against the current rollover_val and count_down, so a direction or R change updates the flag on the next edge.
REQ-020 If R==0, the channel SHALL hold count at 0 regardless of enable, and rollover_flag and wrap_pulse SHALL stay 0.
REQ-021 If R==1, up mode SHALL stay at 1 with rollover_flag high and wrap_pulse high on every enabled cycle; down mode SHALL behave identically.
REQ-022 count_down changing while enabled SHALL take effect on the same edge; there SHALL be no pipeline.
REQ-023 Arithmetic SHALL be NUM_CNT_BITS wide unsigned; comparisons SHALL be unsigned; no intermediate result SHALL truncate.

Reset
REQ-024 While n_rst is low, all count_out bits, rollover_flag and wrap_pulse SHALL be 0, asynchronously.
REQ-025 Reset asserted mid-count SHALL abort the count; after release, counting SHALL restart from 0 as if from power-up.

Configuration
REQ-026 Macro FLEX_CNT_LOAD_EN, when defined, SHALL add inputs load (NUM_CH bits) and load_val (NUM_CH*NUM_CNT_BITS bits, packed as count_out).
REQ-027 With FLEX_CNT_LOAD_EN, load SHALL set count to load_val on the next edge, with rollover_flag computed per REQ-018 and wrap_pulse 0; clear SHALL override load.
REQ-028 Without FLEX_CNT_LOAD_EN, the load ports SHALL be absent and behaviour SHALL be exactly REQ-012 through REQ-025.

Structure
REQ-029 Package flex_cnt_pkg SHALL hold the direction encoding constants DIR_UP=0 and DIR_DOWN=1 and a function computing the next count for one channel.
REQ-030 Sub-module flex_counter_ch SHALL implement one channel; the top SHALL instantiate NUM_CH copies through a generate loop and do only port packing and unpacking.

Verification
REQ-031 Up wrap: ch0 R=3, up, enable for 7 cycles -> count 1,2,3,1,2,3,1; rollover_flag high with each 3; wrap_pulse high on the cycles showing 1 after a 3.
REQ-032 Down wrap: ch1 R=4, down, from reset, enable -> 4,3,2,1,4; rollover_flag high with each 1; wrap_pulse only on the 1->4 transition, not on 0->4.
REQ-033 Priority: ch0 at count 2 with clear and enable both high -> count 0, flag 0; ch1 unaffected.
REQ-034 Edge values: R=0 with enable high for 5 cycles -> count stays 0, flags 0. Then R=1 -> count 1, flag and wrap_pulse high on every enabled cycle after the first.
REQ-035 Reset mid-operation: n_rst pulsed low between edges at count 5 (R=9) -> outputs 0 immediately; after release and 2 enabled cycles -> count 2.
REQ-036 FLEX_CNT_LOAD_EN defined: load=1, load_val=7, R=7, up -> count 7, flag 1, wrap 0; next enabled edge -> count 1, wrap_pulse 1.
